uart_tx_serializer: RTL and testbench

UART transmitter for the debug link. It takes one byte per handshake from the word-to-byte splitter, which drives `tx_start` on `tx_done_tick` and on its first push. It serializes the byte LSB-first as an 8N1 frame on `tx`, with an optional parity bit, using an internal 16x oversampling baud tick. It pulses `tx_done_tick` once per completed frame so the upstream stage can present its next byte.

---
 rtl/uart_tx_serializer.sv | 123 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART 8N1 transmitter with internal 16x baud tick; optional even parity bit
// enabled by defining UART_TX_PARITY_EN.
module uart_tx_serializer #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 326
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_done_tick,
    output logic            busy
);
    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]      state;
    logic [CW-1:0]   baud_cnt;
    logic            tick;
    logic [3:0]      s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] b;
    logic [DBIT-1:0] b_shift;
    logic            accept;

    assign tick    = (baud_cnt == CW'(BAUD_DIV - 1));
    assign accept  = (state == IDLE) && tx_start;
    assign b_shift = b >> 1;
    assign busy    = (state != IDLE);

    // Restarted on acceptance so the first tick lands BAUD_DIV cycles after the start edge.
    always_ff @(posedge clk) begin
        if (reset || accept || tick) baud_cnt <= '0;
        else                         baud_cnt <= baud_cnt + 1'b1;
    end

`ifdef UART_TX_PARITY_EN
    logic par;
    always_ff @(posedge clk) begin
        if (reset)       par <= 1'b0;
        else if (accept) par <= ^din;
    end
`endif

    // tx is loaded together with the state change so it is a clean register output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_start) begin
                        b     <= din;
                        s     <= '0;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: if (tick) begin
                    if (s == 4'd15) begin
                        s     <= '0;
                        n     <= '0;
                        tx    <= b[0];
                        state <= DATA;
                    end else s <= s + 1'b1;
                end
                DATA: if (tick) begin
                    if (s == 4'd15) begin
                        s <= '0;
                        b <= b_shift;
                        if (n == NW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= par;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            n  <= n + 1'b1;
                            tx <= b_shift[0];
                        end
                    end else s <= s + 1'b1;
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (tick) begin
                    if (s == 4'd15) begin
                        s     <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else s <= s + 1'b1;
                end
`endif
                STOP: if (tick) begin
                    if (s == 4'(SB_TICK - 1)) begin
                        s            <= '0;
                        tx_done_tick <= 1'b1;
                        state        <= IDLE;
                    end else s <= s + 1'b1;
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer at BAUD_DIV=2 (T=32 cycles).
module tb_uart_tx_serializer;
    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [7:0] din;
    logic       tx;
    logic       tx_done_tick;
    logic       busy;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int   c;
        int   kind;  // 0 tx, 1 busy, 2 tx_done_tick
        logic val;
    } chk_t;

    chk_t lq[$];
    int   dq[$];

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    uart_tx_serializer #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(2)) dut (
        .clk(clk), .reset(reset), .tx_start(tx_start), .din(din),
        .tx(tx), .tx_done_tick(tx_done_tick), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_lvl(input int c, input int kind, input logic v);
        chk_t e;
        e.c = c; e.kind = kind; e.val = v;
        lq.push_back(e);
    endtask

    // Expected frame started at acceptance cycle e; only checks before e+upto are queued.
    task automatic push_frame(input int e, input logic [7:0] d, input int upto);
        logic [10:0] bits;
        int done_off;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
`ifdef UART_TX_PARITY_EN
        bits[9] = ^d;
`endif
        expect_lvl(e + 1, 0, 1'b0);
        expect_lvl(e + 1, 1, 1'b1);
        for (int k = 0; k < NB; k++)
            if (16 + 32 * k < upto) expect_lvl(e + 16 + 32 * k, 0, bits[k]);
        done_off = 1 + NB * 32;
        if (done_off < upto) begin
            expect_lvl(e + done_off, 1, 1'b0);
            expect_lvl(e + done_off, 2, 1'b1);
            expect_lvl(e + done_off + 1, 2, 1'b0);
            dq.push_back(e + done_off);
        end
    endtask

    always @(negedge clk) begin
        logic act;
        while (lq.size() > 0 && lq[0].c <= cyc) begin
            chk_t e;
            e = lq.pop_front();
            act = (e.kind == 0) ? tx : (e.kind == 1) ? busy : tx_done_tick;
            checks++;
            if (e.c != cyc || act !== e.val) begin
                errors++;
                $display("FAIL lvl kind=%0d at cycle %0d (now %0d): got %b want %b",
                         e.kind, e.c, cyc, act, e.val);
            end
        end
        if (tx_done_tick === 1'b1) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL done_pulse: unexpected pulse at cycle %0d, none expected", cyc);
            end else begin
                int want;
                want = dq.pop_front();
                if (want != cyc) begin
                    errors++;
                    $display("FAIL done_cycle: got %0d want %0d", cyc, want);
                end
            end
        end
    end

    initial begin
        int e, e1, e2;
        bit seen;
        reset = 1'b1; tx_start = 1'b0; din = 8'h00;
        for (int c = 1; c <= 103; c++) begin
            expect_lvl(c, 0, 1'b1);
            expect_lvl(c, 1, 1'b0);
            expect_lvl(c, 2, 1'b0);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        while (cyc < 110) @(negedge clk);

        // single frame 0xA5: samples 0,1,0,1,0,0,1,0,1,1 then done at E+321
        e = cyc; din = 8'hA5; tx_start = 1'b1;
        push_frame(e, 8'hA5, 100000);
        @(negedge clk); tx_start = 1'b0;
        repeat (360) @(negedge clk);

        // back-to-back 0x00 then 0xFF, second start on the done cycle
        e1 = cyc; din = 8'h00; tx_start = 1'b1;
        push_frame(e1, 8'h00, 100000);
        @(negedge clk); tx_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (tx_done_tick === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b_wait: no done pulse within bound, want at %0d", e1 + 1 + NB * 32);
        end
        e2 = cyc; din = 8'hFF; tx_start = 1'b1;
        checks++;
        if (e2 != e1 + 1 + NB * 32) begin
            errors++;
            $display("FAIL b2b_gap: second accept at %0d want %0d", e2, e1 + 1 + NB * 32);
        end
        push_frame(e2, 8'hFF, 100000);
        @(negedge clk); tx_start = 1'b0;
        repeat (360) @(negedge clk);

        // start request while busy is ignored
        e = cyc; din = 8'h81; tx_start = 1'b1;
        push_frame(e, 8'h81, 100000);
        @(negedge clk); tx_start = 1'b0;
        while (cyc < e + 100) @(negedge clk);
        din = 8'h3C; tx_start = 1'b1;
        @(negedge clk); tx_start = 1'b0;
        repeat (300) @(negedge clk);

        // reset mid-frame abandons the frame
        e = cyc; din = 8'h81; tx_start = 1'b1;
        push_frame(e, 8'h81, 150);
        @(negedge clk); tx_start = 1'b0;
        while (cyc < e + 150) @(negedge clk);
        reset = 1'b1;
        for (int c = e + 151; c <= e + 550; c++) begin
            expect_lvl(c, 0, 1'b1);
            if (c == e + 151) expect_lvl(c, 1, 1'b0);
            expect_lvl(c, 2, 1'b0);
        end
        @(negedge clk); reset = 1'b0;
        repeat (420) @(negedge clk);

`ifdef UART_TX_PARITY_EN
        // 0x07: parity bit 1 at E+304, done at E+353
        e = cyc; din = 8'h07; tx_start = 1'b1;
        push_frame(e, 8'h07, 100000);
        @(negedge clk); tx_start = 1'b0;
        repeat (400) @(negedge clk);
`endif

        repeat (10) @(negedge clk);
        while (lq.size() > 0) begin
            chk_t x;
            x = lq.pop_front();
            checks++; errors++;
            $display("FAIL lvl_unchecked: kind=%0d cycle %0d never reached, want %b", x.kind, x.c, x.val);
        end
        while (dq.size() > 0) begin
            int w;
            w = dq.pop_front();
            checks++; errors++;
            $display("FAIL done_missing: got no pulse, want one at cycle %0d", w);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
